// File: rtl/usb3_fifo_rd_ctrl.sv
// usb3_fifo_rd_ctrl: synchronous-slave-FIFO burst reader for the USB3 bridge.
// Rev 1.0 - initial release.
`timescale 1ns/1ps
`default_nettype none

module usb3_fifo_rd_ctrl #(
  parameter int         BURST_LEN = 256,
  parameter int         RD_LAT    = 2,
  parameter logic [1:0] FIFO_ADDR = 2'b11,
  parameter int         GAP_CYC   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        USB3_FLAGA,
  input  logic [31:0] USB3_DQ,
  input  logic        rd_en,
  output logic        USB3_SLCS_n,
  output logic        USB3_SLOE_n,
  output logic        USB3_SLRD_n,
  output logic [1:0]  USB3_A,
  output logic [31:0] data,
  output logic        data_valid,
  output logic [3:0]  usb_rd_state,
  output logic        burst_done
);

  // State encodings double as the published phase code where they coincide.
  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_SELECT = 4'd1;
  localparam logic [3:0] S_OE     = 4'd2;
  localparam logic [3:0] S_STROBE = 4'd3;
  localparam logic [3:0] S_TAIL   = 4'd7;
  localparam logic [3:0] S_DONE   = 4'd8;
  localparam logic [3:0] S_GAP    = 4'd9;

  localparam logic [8:0] STROBE_LAST = 9'(BURST_LEN - 1);
  localparam logic [8:0] TAIL_LAST   = 9'(RD_LAT);
  localparam logic [8:0] GAP_LAST    = 9'(GAP_CYC - 1);

  logic [3:0]        state_q, state_d;
  logic [8:0]        cnt_q, cnt_d;
  logic [RD_LAT-1:0] pipe_q, pipe_d;
  logic              slcs_n_q, sloe_n_q, slrd_n_q;
  logic [1:0]        addr_q;
  logic [31:0]       data_q;
  logic              valid_q, done_q;
  logic [3:0]        code_q, code_d;
  logic              capture;
  logic              sel_d, oe_d;

  assign capture = pipe_q[RD_LAT-1];

  generate
    if (RD_LAT == 1) begin : g_pipe_single
      assign pipe_d = ~slrd_n_q;
    end else begin : g_pipe_multi
      assign pipe_d = {pipe_q[RD_LAT-2:0], ~slrd_n_q};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (USB3_FLAGA && rd_en) state_d = S_SELECT;
      end
      S_SELECT: state_d = S_OE;
      S_OE: begin
        state_d = S_STROBE;
        cnt_d   = '0;
      end
      S_STROBE: begin
        if (cnt_q == STROBE_LAST) begin
          state_d = S_TAIL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      // TAIL runs RD_LAT+1 cycles so the last captured word is out before DONE.
      S_TAIL: begin
        if (cnt_q == TAIL_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      S_DONE: begin
        state_d = S_GAP;
        cnt_d   = '0;
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    sel_d = (state_d == S_SELECT) || (state_d == S_OE) ||
            (state_d == S_STROBE) || (state_d == S_TAIL);
    oe_d  = (state_d == S_OE) || (state_d == S_STROBE) || (state_d == S_TAIL);
    case (state_d)
      S_SELECT: code_d = 4'd1;
      S_OE:     code_d = 4'd2;
      S_STROBE: code_d = capture ? 4'd6 : 4'd3;
      S_TAIL:   code_d = capture ? 4'd6 : 4'd7;
      S_DONE:   code_d = 4'd8;
      S_GAP:    code_d = 4'd9;
      default:  code_d = 4'd0;
    endcase
  end

  // Outputs are registered from the next state so each pin matches its phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      pipe_q   <= '0;
      slcs_n_q <= 1'b1;
      sloe_n_q <= 1'b1;
      slrd_n_q <= 1'b1;
      addr_q   <= 2'b00;
      data_q   <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      code_q   <= 4'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pipe_q   <= pipe_d;
      slcs_n_q <= ~sel_d;
      sloe_n_q <= ~oe_d;
      slrd_n_q <= (state_d != S_STROBE);
      addr_q   <= sel_d ? FIFO_ADDR : 2'b00;
      valid_q  <= capture;
      if (capture) data_q <= USB3_DQ;
      done_q   <= (state_d == S_DONE);
      code_q   <= code_d;
    end
  end

  assign USB3_SLCS_n  = slcs_n_q;
  assign USB3_SLOE_n  = sloe_n_q;
  assign USB3_SLRD_n  = slrd_n_q;
  assign USB3_A       = addr_q;
  assign data         = data_q;
  assign data_valid   = valid_q;
  assign usb_rd_state = code_q;
  assign burst_done   = done_q;

endmodule

`default_nettype wire

// File: tb/tb_usb3_fifo_rd_ctrl.sv
// Bench for usb3_fifo_rd_ctrl: three configurations share one stimulus stream,
// each with its own FIFO-chip model and timeline-based reference.
`timescale 1ns/1ps
`default_nettype none

module tb_usb3_fifo_rd_ctrl;

  localparam int NI  = 3;
  localparam int GAP = 4;

  function automatic int bl_of(int k);
    return (k == 0) ? 256 : 2;
  endfunction
  function automatic int rl_of(int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
  endfunction

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flaga;
  logic        rd_en;
  logic [31:0] dq      [NI];
  logic        slcs_n  [NI];
  logic        sloe_n  [NI];
  logic        slrd_n  [NI];
  logic [1:0]  a       [NI];
  logic [31:0] data    [NI];
  logic        dv      [NI];
  logic [3:0]  code    [NI];
  logic        done    [NI];

  always #5 clk = ~clk;

  generate
    for (genvar k = 0; k < NI; k++) begin : g_dut
      localparam int BL = (k == 0) ? 256 : 2;
      localparam int RL = (k == 0) ? 2 : ((k == 1) ? 1 : 4);
      usb3_fifo_rd_ctrl #(
        .BURST_LEN(BL), .RD_LAT(RL), .FIFO_ADDR(2'b11), .GAP_CYC(GAP)
      ) u_dut (
        .clk(clk), .rst_n(rst_n), .USB3_FLAGA(flaga), .USB3_DQ(dq[k]),
        .rd_en(rd_en), .USB3_SLCS_n(slcs_n[k]), .USB3_SLOE_n(sloe_n[k]),
        .USB3_SLRD_n(slrd_n[k]), .USB3_A(a[k]), .data(data[k]),
        .data_valid(dv[k]), .usb_rd_state(code[k]), .burst_done(done[k])
      );
    end
  endgenerate

  int n_checks = 0;
  int n_err    = 0;
  int tc       = 0;

  // Chip model: a strobe seen low in cycle X puts the next word on DQ for cycle X+RD_LAT.
  logic [7:0]  hist     [NI];
  logic [31:0] chip_cnt [NI];
  always @(negedge clk or negedge rst_n) begin
    for (int k = 0; k < NI; k++) begin
      logic [7:0] nh;
      if (!rst_n) begin
        hist[k]     <= 8'hFF;
        chip_cnt[k] <= 32'd0;
        dq[k]       <= 32'd0;
      end else begin
        nh = {hist[k][6:0], slrd_n[k]};
        hist[k] <= nh;
        if (!nh[rl_of(k)]) begin
          dq[k]       <= chip_cnt[k];
          chip_cnt[k] <= chip_cnt[k] + 32'd1;
        end else begin
          dq[k] <= 32'hDEAD_0000 | 32'(k);
        end
      end
    end
  end

  // Reference: a burst accepted in cycle s fixes every output as a function of t-s.
  logic        busy_m  [NI];
  int          s_m     [NI];
  int          words_m [NI];
  logic [63:0] exp_q   [NI][$];

  always @(posedge clk) tc <= tc + 1;

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < NI; k++) begin
      int bl, rl;
      bl = bl_of(k);
      rl = rl_of(k);
      if (!rst_n) begin
        busy_m[k]  <= 1'b0;
        s_m[k]     <= 0;
        words_m[k] <= 0;
        exp_q[k].delete();
      end else if (flaga && rd_en &&
                   (!busy_m[k] || (tc - s_m[k]) >= 5 + rl + bl + GAP)) begin
        busy_m[k]  <= 1'b1;
        s_m[k]     <= tc;
        for (int i = 0; i < bl; i++)
          exp_q[k].push_back({32'(tc + 4 + rl + i), 32'(words_m[k] + i)});
        words_m[k] <= words_m[k] + bl;
      end
    end
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst=%0d cycle=%0d actual=%0h expected=%0h", nm, k, tc, act, exp);
    end
  endtask

  logic [31:0] last_data [NI];

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      int bl, rl, d;
      logic act, e_slcs, e_sloe, e_slrd, e_dv, e_done;
      logic [3:0] e_code;
      logic [63:0] ent;
      bl = bl_of(k);
      rl = rl_of(k);
      if (!rst_n) begin
        chk("rst_slcs", k, 32'(slcs_n[k]), 32'd1);
        chk("rst_sloe", k, 32'(sloe_n[k]), 32'd1);
        chk("rst_slrd", k, 32'(slrd_n[k]), 32'd1);
        chk("rst_addr", k, 32'(a[k]), 32'd0);
        chk("rst_data", k, data[k], 32'd0);
        chk("rst_valid", k, 32'(dv[k]), 32'd0);
        chk("rst_state", k, 32'(code[k]), 32'd0);
        chk("rst_done", k, 32'(done[k]), 32'd0);
        last_data[k] = 32'd0;
      end else begin
        d      = tc - s_m[k];
        act    = busy_m[k] && d >= 1 && d <= 4 + rl + bl + GAP;
        e_slcs = !(act && d <= 3 + rl + bl);
        e_sloe = !(act && d >= 2 && d <= 3 + rl + bl);
        e_slrd = !(act && d >= 3 && d <= 2 + bl);
        e_dv   = act && d >= 4 + rl && d <= 3 + rl + bl;
        e_done = act && d == 4 + rl + bl;
        if (!act)                   e_code = 4'd0;
        else if (d == 1)            e_code = 4'd1;
        else if (d == 2)            e_code = 4'd2;
        else if (d <= 2 + bl)       e_code = e_dv ? 4'd6 : 4'd3;
        else if (d <= 3 + rl + bl)  e_code = e_dv ? 4'd6 : 4'd7;
        else if (d == 4 + rl + bl)  e_code = 4'd8;
        else                        e_code = 4'd9;
        chk("slcs_n", k, 32'(slcs_n[k]), 32'(e_slcs));
        chk("sloe_n", k, 32'(sloe_n[k]), 32'(e_sloe));
        chk("slrd_n", k, 32'(slrd_n[k]), 32'(e_slrd));
        chk("addr", k, 32'(a[k]), e_slcs ? 32'd0 : 32'd3);
        chk("data_valid", k, 32'(dv[k]), 32'(e_dv));
        chk("rd_state", k, 32'(code[k]), 32'(e_code));
        chk("burst_done", k, 32'(done[k]), 32'(e_done));
        if (dv[k] === 1'b1) begin
          if (exp_q[k].size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL word_unexpected inst=%0d cycle=%0d actual=%0h expected=none",
                     k, tc, data[k]);
          end else begin
            ent = exp_q[k].pop_front();
            chk("word_value", k, data[k], ent[31:0]);
            chk("word_cycle", k, 32'(tc), ent[63:32]);
            last_data[k] = ent[31:0];
          end
        end else begin
          chk("data_hold", k, data[k], last_data[k]);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    flaga = 1'b0;
    rd_en = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(2);
    // Back-to-back bursts, then FLAGA drops around strobe 100 of the third.
    flaga = 1'b1;
    rd_en = 1'b1;
    step(2 * 267 + 103);
    flaga = 1'b0;
    step(400);
    // Downstream holds off for 1000 cycles, then permits.
    rd_en = 1'b0;
    flaga = 1'b1;
    step(1000);
    rd_en = 1'b1;
    step(53);
    // Reset mid-burst, asserted between edges.
    @(posedge clk);
    #1 rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(300);
    for (int i = 0; i < 1500; i++) begin
      flaga = ($urandom_range(0, 3) != 0);
      rd_en = ($urandom_range(0, 2) != 0);
      step(1);
    end
    flaga = 1'b0;
    rd_en = 1'b0;
    step(300);
    for (int k = 0; k < NI; k++)
      chk("words_outstanding", k, 32'(exp_q[k].size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
